sparse_idx_scheduler: RTL and testbench
=======================================

// Module: sparse_idx_scheduler
// PURPOSE
// - Shares one free-running pseudo-random index source among NREQ requesters; each grant yields a burst of W
//   distinct indices in [0,RANGE): the positions of the ones of one sparse binary hypervector.
// - Sits between the random-index generator (output feeds rand_idx_in) and the hypervector encode/bind units.
// PARAMETERS
// - RANGE  64  hypervector dimension; index range [0,RANGE-1]
// - W      8   indices (ones) per burst; 1 <= W <= RANGE, else elaboration $error
// - NREQ   4   number of requesters, >= 2
// - IDXW   $clog2(RANGE)  index width (derived, not overridden)
// PORTS
// - clk            in   1     clock, all logic on posedge
// - arst_n_in      in   1     reset, asynchronous, active-low
// - req_in         in   NREQ  per-requester burst request, level
// - rand_idx_in    in   IDXW  new pseudo-random index every cycle from the generator
// - grant_out      out  NREQ  one-hot owner of the current burst, 0 when idle
// - idx_out        out  IDXW  index being offered
// - idx_valid_out  out  1     idx_out valid
// - idx_ready_in   in   1     consumer accepts idx_out when high with idx_valid_out
// - idx_last_out   out  1     high with idx_valid_out on the W-th index of the burst
// - busy_out       out  1     burst in progress (state != IDLE)
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0; state IDLE; burst count 0; bitmap 0; RR pointer 0.
// - FSM IDLE -> DRAW -> SEND -> (DRAW | IDLE); all outputs registered.
// - IDLE: if |req_in, select the first set bit at or after the RR pointer (wraps NREQ-1 -> 0).
//   Next cycle: grant_out = that one-hot; busy_out = 1; count = 0; bitmap = 0; RR pointer = winner+1 mod NREQ.
// - DRAW: sample rand_idx_in. If bitmap[idx] == 0: idx_out <= idx, idx_valid_out <= 1, set bitmap[idx],
//   idx_last_out <= (count == W-1), go to SEND. Otherwise stay in DRAW and resample next cycle.
// - SEND: hold idx_out, idx_valid_out and idx_last_out stable until idx_ready_in.
//   On the handshake: idx_valid_out <= 0, idx_last_out <= 0.
//   If last: grant_out <= 0, busy_out <= 0, go to IDLE. Else count++, go to DRAW.
// - Throughput: at most 1 index per 2 cycles. Minimum burst latency from grant is 2*W cycles.
// - A grant is held for the whole burst: req_in deassertion or new requests mid-burst are ignored.
//   A new arbitration occurs only in IDLE, so the cycle after a burst completes is always idle.
// - count is $clog2(W+1) bits with no wrap. The bitmap is RANGE bits wide, indexed by the raw IDXW value.
//   Values >= RANGE (non-power-of-2 RANGE) are rejected like duplicates.
// - Reset mid-burst aborts the burst: no partial-burst completion; the RR pointer restarts at 0.
// CONFIGURATION
// - SPARSE_IDX_DUP_CHECK_EN defined: bitmap present; duplicates and out-of-range values are rejected, so a
//   burst is W distinct indices.
// - SPARSE_IDX_DUP_CHECK_EN undefined: no bitmap; every DRAW sample is accepted, taken modulo RANGE.
//   Duplicates are possible; DRAW always lasts exactly 1 cycle.
// TESTING (RANGE=64, W=8, NREQ=4 unless stated; bench drives rand_idx_in directly)
// - req_in=0001 held, rand_idx 0,1,..7 one per cycle in DRAW, ready=1 -> grant_out=0001 1 cycle after req;
//   idx_out 0..7, idx_last_out only with 7; busy_out/grant_out return to 0 after the 8th handshake.
// - rand_idx 5,5,5,9 on successive DRAW cycles, after 5 already sent -> with _EN: next idx_out=9,
//   DRAW lasts 4 cycles; without _EN: idx_out=5 again after 1 cycle.
// - req_in=1111 held for 5 bursts -> grant_out sequence 0001,0010,0100,1000,0001,
//   with one idle cycle between bursts.
// - idx_ready_in low for 3 cycles while idx_valid_out=1 with idx_out=12 -> idx_out stays 12, valid stays 1,
//   count unchanged; the handshake occurs in the 4th cycle.
// - arst_n_in low after 3 handshakes of a req_in=0100 burst -> all outputs 0 immediately.
//   After release with req_in=0110: grant_out=0010 (RR=0); burst is 8 fresh indices; a previously sent
//   index is accepted again.
// - RANGE=8, W=8, rand_idx from a 5x+1 mod 8 sequence -> with _EN: 8 distinct indices covering 0..7;
//   no deadlock; last asserted on the 8th.

Source files
------------

// File: rtl/sparse_idx_scheduler.sv
`default_nettype none
// sparse_idx_scheduler: round-robin arbiter sharing one random-index source; each grant issues W indices.
// Build option SPARSE_IDX_DUP_CHECK_EN adds an occupancy bitmap so a burst carries W distinct indices.
module sparse_idx_scheduler #(
  parameter int RANGE = 64,
  parameter int W     = 8,
  parameter int NREQ  = 4,
  localparam int IDXW = $clog2(RANGE)
) (
  input  logic            clk,
  input  logic            arst_n_in,
  input  logic [NREQ-1:0] req_in,
  input  logic [IDXW-1:0] rand_idx_in,
  output logic [NREQ-1:0] grant_out,
  output logic [IDXW-1:0] idx_out,
  output logic            idx_valid_out,
  input  logic            idx_ready_in,
  output logic            idx_last_out,
  output logic            busy_out
);
  localparam int CW = $clog2(W + 1);
  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);

  generate
    if (W < 1 || W > RANGE) begin : g_bad_w
      $error("sparse_idx_scheduler: W must lie in [1, RANGE]");
    end
    if (NREQ < 2) begin : g_bad_nreq
      $error("sparse_idx_scheduler: NREQ must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [IDXW-1:0] idx_n;
  logic            valid_n, last_n, busy_n;
  logic [CW-1:0]   count, count_n;
  logic [PW-1:0]   rr, rr_n;

  logic            accept;
  logic [IDXW-1:0] draw_idx;

`ifdef SPARSE_IDX_DUP_CHECK_EN
  logic [RANGE-1:0] bitmap, bitmap_n;
  logic             in_range;

  // Raw values beyond RANGE-1 can only appear when RANGE is not a power of two.
  generate
    if (RANGE == (1 << IDXW)) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [IDXW:0] RANGE_W = (IDXW + 1)'(RANGE);
      assign in_range = ({1'b0, rand_idx_in} < RANGE_W);
    end
  endgenerate

  assign accept   = in_range && !bitmap[rand_idx_in];
  assign draw_idx = rand_idx_in;
`else
  assign accept = 1'b1;
  generate
    if (RANGE == (1 << IDXW)) begin : g_pow2
      assign draw_idx = rand_idx_in;
    end else begin : g_npow2
      localparam logic [IDXW:0] RANGE_W = (IDXW + 1)'(RANGE);
      logic [IDXW:0] wrapped;
      assign wrapped  = {1'b0, rand_idx_in} % RANGE_W;
      assign draw_idx = wrapped[IDXW-1:0];
    end
  endgenerate
`endif

  logic          found;
  logic [PW-1:0] winner;

  always_comb begin
    int pos;
    found  = 1'b0;
    winner = '0;
    pos    = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(rr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req_in[PW'(pos)]) begin
        found  = 1'b1;
        winner = PW'(pos);
      end
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant_out;
    idx_n    = idx_out;
    valid_n  = idx_valid_out;
    last_n   = idx_last_out;
    busy_n   = busy_out;
    count_n  = count;
    rr_n     = rr;
`ifdef SPARSE_IDX_DUP_CHECK_EN
    bitmap_n = bitmap;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_n          = DRAW;
          grant_n          = '0;
          grant_n[winner]  = 1'b1;
          busy_n           = 1'b1;
          count_n          = '0;
          rr_n             = (winner == LAST_REQ) ? '0 : winner + PW'(1);
`ifdef SPARSE_IDX_DUP_CHECK_EN
          bitmap_n         = '0;
`endif
        end
      end
      DRAW: begin
        if (accept) begin
          state_n = SEND;
          idx_n   = draw_idx;
          valid_n = 1'b1;
          last_n  = (count == LAST_CNT);
`ifdef SPARSE_IDX_DUP_CHECK_EN
          bitmap_n[rand_idx_in] = 1'b1;
`endif
        end
      end
      SEND: begin
        if (idx_ready_in) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          if (idx_last_out) begin
            state_n = IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
          end else begin
            state_n = DRAW;
            count_n = count + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state         <= IDLE;
      grant_out     <= '0;
      idx_out       <= '0;
      idx_valid_out <= 1'b0;
      idx_last_out  <= 1'b0;
      busy_out      <= 1'b0;
      count         <= '0;
      rr            <= '0;
`ifdef SPARSE_IDX_DUP_CHECK_EN
      bitmap        <= '0;
`endif
    end else begin
      state         <= state_n;
      grant_out     <= grant_n;
      idx_out       <= idx_n;
      idx_valid_out <= valid_n;
      idx_last_out  <= last_n;
      busy_out      <= busy_n;
      count         <= count_n;
      rr            <= rr_n;
`ifdef SPARSE_IDX_DUP_CHECK_EN
      bitmap        <= bitmap_n;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sparse_idx_scheduler.sv
`default_nettype none
// tb_sparse_idx_scheduler: directed bench for sparse_idx_scheduler (64/8/4 and 8/8/4 instances).
module tb_sparse_idx_scheduler;
  logic       clk;
  logic       arst_n;
  logic [3:0] req;
  logic [5:0] rand_idx;
  logic [3:0] grant;
  logic [5:0] idx;
  logic       valid, ready, last, busy;

  logic [3:0] req8;
  logic [2:0] rand8;
  logic [3:0] grant8;
  logic [2:0] idx8;
  logic       valid8, ready8, last8, busy8;

  int total  = 0;
  int passed = 0;

  sparse_idx_scheduler dut (
    .clk(clk), .arst_n_in(arst_n), .req_in(req), .rand_idx_in(rand_idx),
    .grant_out(grant), .idx_out(idx), .idx_valid_out(valid), .idx_ready_in(ready),
    .idx_last_out(last), .busy_out(busy)
  );

  sparse_idx_scheduler #(.RANGE(8), .W(8), .NREQ(4)) dut8 (
    .clk(clk), .arst_n_in(arst_n), .req_in(req8), .rand_idx_in(rand8),
    .grant_out(grant8), .idx_out(idx8), .idx_valid_out(valid8), .idx_ready_in(ready8),
    .idx_last_out(last8), .busy_out(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expects the DUT in DRAW; offers v, checks it is issued, then completes the handshake.
  task automatic do_idx(input int v, input logic lst);
    rand_idx = 6'(v);
    tick();
    check("idx_valid", {31'd0, valid}, 32'd1);
    check("idx_out", {26'd0, idx}, v);
    check("idx_last", {31'd0, last}, {31'd0, lst});
    tick();
    check("valid_drop", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    logic [3:0] exp_g [5];
    int         exp8 [8];
    logic [2:0] got [8];
    logic       gotlast [8];
    int         n;
    int         x;
    logic       done;

    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef SPARSE_IDX_DUP_CHECK_EN
    exp8 = '{0, 6, 4, 2, 1, 7, 5, 3};
`else
    exp8 = '{0, 6, 4, 2, 0, 6, 4, 2};
`endif

    arst_n = 1'b0; req = '0; rand_idx = '0; ready = 1'b1;
    req8 = '0; rand8 = '0; ready8 = 1'b1;
    #1;
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_idx", {26'd0, idx}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    tick();
    arst_n = 1'b1;
    tick();

    // Basic burst 0..7 from requester 0.
    req = 4'b0001; rand_idx = 6'd0;
    tick();
    check("b1_grant", {28'd0, grant}, 32'h1);
    check("b1_busy", {31'd0, busy}, 32'd1);
    check("b1_valid0", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_idx(i, (i == 7));
    end
    req = 4'b0000;
    check("b1_end_grant", {28'd0, grant}, 32'd0);
    check("b1_end_busy", {31'd0, busy}, 32'd0);
    tick();
    check("b1_idle_busy", {31'd0, busy}, 32'd0);

    // Repeated draws after 5 has been sent.
    req = 4'b0001; rand_idx = 6'd5;
    tick();
    check("b2_grant", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    do_idx(5, 1'b0);
    rand_idx = 6'd5;
    tick();
`ifdef SPARSE_IDX_DUP_CHECK_EN
    check("dup_rej1", {31'd0, valid}, 32'd0);
    tick();
    check("dup_rej2", {31'd0, valid}, 32'd0);
    tick();
    check("dup_rej3", {31'd0, valid}, 32'd0);
    rand_idx = 6'd9;
    tick();
    check("dup_valid", {31'd0, valid}, 32'd1);
    check("dup_idx", {26'd0, idx}, 32'd9);
`else
    check("dup_valid", {31'd0, valid}, 32'd1);
    check("dup_idx", {26'd0, idx}, 32'd5);
`endif
    tick();
    check("dup_drop", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      do_idx(20 + i, (i == 5));
    end
    check("b2_end_busy", {31'd0, busy}, 32'd0);
    check("b2_end_grant", {28'd0, grant}, 32'd0);

    // Reset restores the round-robin pointer to 0 before the fairness run.
    arst_n = 1'b0;
    #1;
    tick();
    arst_n = 1'b1;

    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      rand_idx = 6'd0;
      tick();
      check("rr_grant", {28'd0, grant}, {28'd0, exp_g[b]});
      check("rr_busy", {31'd0, busy}, 32'd1);
      for (int k = 0; k < 8; k++) begin
        do_idx(k, (k == 7));
      end
      if (b == 4) req = 4'b0000;
      check("rr_idle_grant", {28'd0, grant}, 32'd0);
      check("rr_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Backpressure: idx 12 held for three stalled cycles.
    req = 4'b0001;
    tick();
    check("bp_grant", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    ready = 1'b0; rand_idx = 6'd12;
    tick();
    check("bp_valid", {31'd0, valid}, 32'd1);
    check("bp_idx", {26'd0, idx}, 32'd12);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("bp_hold_valid", {31'd0, valid}, 32'd1);
      check("bp_hold_idx", {26'd0, idx}, 32'd12);
      check("bp_hold_last", {31'd0, last}, 32'd0);
    end
    ready = 1'b1;
    tick();
    check("bp_handshake", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      do_idx(i, (i == 6));
    end
    check("bp_end_busy", {31'd0, busy}, 32'd0);

    // Reset mid-burst of requester 2.
    req = 4'b0100;
    tick();
    check("ab_grant", {28'd0, grant}, 32'h4);
    req = 4'b0000;
    do_idx(30, 1'b0);
    do_idx(31, 1'b0);
    do_idx(32, 1'b0);
    arst_n = 1'b0;
    #1;
    check("ab_grant0", {28'd0, grant}, 32'd0);
    check("ab_busy0", {31'd0, busy}, 32'd0);
    check("ab_valid0", {31'd0, valid}, 32'd0);
    check("ab_idx0", {26'd0, idx}, 32'd0);
    check("ab_last0", {31'd0, last}, 32'd0);
    tick();
    arst_n = 1'b1;
    req = 4'b0110;
    tick();
    check("ab_regrant", {28'd0, grant}, 32'h2);
    req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      do_idx(30 + i, (i == 7));
    end
    check("ab_end_busy", {31'd0, busy}, 32'd0);

    // RANGE=8 instance with a free-running 5x+1 mod 8 generator.
    req8 = 4'b0001; rand8 = 3'd0;
    tick();
    check("r8_grant", {28'd0, grant8}, 32'h1);
    req8 = 4'b0000;
    x = 0; n = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      rand8 = 3'(x);
      tick();
      if (valid8 && n < 8) begin
        got[n]     = idx8;
        gotlast[n] = last8;
        n++;
        if (last8) done = 1'b1;
      end
      x = (5 * x + 1) % 8;
    end
    check("r8_done", {31'd0, done}, 32'd1);
    check("r8_count", n, 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        check("r8_idx", {29'd0, got[k]}, exp8[k]);
        check("r8_last", {31'd0, gotlast[k]}, {31'd0, (k == 7)});
      end
    end
    tick();
    check("r8_end_busy", {31'd0, busy8}, 32'd0);
    check("r8_end_grant", {28'd0, grant8}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
